// File: rtl/conv_relu_pool_engine.sv
// conv_relu_pool_engine
//   3x3 convolution engine with zero padding, bias, round-to-nearest, positive saturation and
//   ReLU. It reads an IMG_W x IMG_H image from an external ROM and writes one result per pixel
//   to layer-0 memory. When the MAXPOOL_EN macro is defined, a 2x2/stride-2 max-pool pass then
//   reads layer 0 back and writes layer-1 memory.
//
//   Build option: `define MAXPOOL_EN to build the POOL state, the read port and layer-1 writes.
//   Without it, crd/caddr_rd are tied low and cdata_rd is ignored.
//
// Ports
//   clk       clock, rising edge
//   reset     synchronous active-low reset
//   ready     host start request, sampled only while idle
//   busy      engine running (high from the cycle after start through the DONE cycle)
//   iaddr     image ROM address, row-major y*IMG_W+x
//   idata     image ROM data, one cycle after iaddr
//   cwr       result memory write strobe (1-cycle pulse)
//   caddr_wr  result memory write address
//   cdata_wr  result memory write data
//   crd       result memory read strobe (1-cycle pulse)
//   caddr_rd  result memory read address
//   cdata_rd  result memory read data, one cycle after crd
//   csel      memory select: 000 none, 001 layer 0, 011 layer 1
module conv_relu_pool_engine #(
   parameter int unsigned IMG_W  = 64,
   parameter int unsigned IMG_H  = 64,
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 20,
   parameter int unsigned FRAC_W = 16,
   // Default is the identity kernel: centre tap (k=4) = 1.0, all others 0.
   parameter logic [9*DATA_W-1:0] KERNEL =
      {{(5*DATA_W-FRAC_W-1){1'b0}}, 1'b1, {(4*DATA_W+FRAC_W){1'b0}}},
   parameter logic [DATA_W-1:0] BIAS = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ready,
   output logic              busy,
   output logic [ADDR_W-1:0] iaddr,
   input  logic [DATA_W-1:0] idata,
   output logic              cwr,
   output logic [ADDR_W-1:0] caddr_wr,
   output logic [DATA_W-1:0] cdata_wr,
   output logic              crd,
   output logic [ADDR_W-1:0] caddr_rd,
   input  logic [DATA_W-1:0] cdata_rd,
   output logic [2:0]        csel
);

   localparam int unsigned X_W   = $clog2(IMG_W);
   localparam int unsigned Y_W   = $clog2(IMG_H);
   localparam int unsigned ACC_W = 2*DATA_W + 4;
   localparam int unsigned PAD_W = ACC_W - DATA_W - FRAC_W;

   localparam logic [2:0] CSEL_NONE = 3'b000;
   localparam logic [2:0] CSEL_L0   = 3'b001;
`ifdef MAXPOOL_EN
   localparam logic [2:0] CSEL_L1   = 3'b011;
`endif

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StConv = 2'd1,
`ifdef MAXPOOL_EN
      StPool = 2'd2,
`endif
      StDone = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [3:0]              cyc_q, cyc_d;
   logic [X_W-1:0]          x_q, x_d;
   logic [Y_W-1:0]          y_q, y_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    tap_ok_q, tap_ok;

`ifdef MAXPOOL_EN
   logic [X_W-2:0]          px_q, px_d;
   logic [Y_W-2:0]          py_q, py_d;
   logic [DATA_W-1:0]       max_q, max_d;
`endif

   // ---------------------------------------------------------------------------------------
   // Tap geometry: cycle c in 0..8 addresses tap k=c, dy=k/3, dx=k%3.
   // ---------------------------------------------------------------------------------------
   logic [1:0]     dy, dx;
   logic [3:0]     row_base;
   logic [X_W-1:0] tap_x;
   logic [Y_W-1:0] tap_y;

   always_comb begin
      dy       = (cyc_q >= 4'd6) ? 2'd2 : ((cyc_q >= 4'd3) ? 2'd1 : 2'd0);
      row_base = {1'b0, dy, 1'b0} + {2'b00, dy};
      dx       = 2'(cyc_q - row_base);
      // Wraps only when the tap is out of bounds, in which case the address is unused.
      tap_x    = x_q + X_W'(dx) - X_W'(1);
      tap_y    = y_q + Y_W'(dy) - Y_W'(1);
      tap_ok   = (state_q == StConv) && (cyc_q <= 4'd8)
               && !((dx == 2'd0) && (x_q == '0))
               && !((dx == 2'd2) && (x_q == X_W'(IMG_W - 1)))
               && !((dy == 2'd0) && (y_q == '0))
               && !((dy == 2'd2) && (y_q == Y_W'(IMG_H - 1)));
   end

   // ---------------------------------------------------------------------------------------
   // Multiply: data arriving in cycle c belongs to tap c-1.
   // ---------------------------------------------------------------------------------------
   logic signed [DATA_W-1:0]   w_sel;
   logic signed [2*DATA_W-1:0] prod;
   logic [ACC_W-1:0]           prod_ext;

   always_comb begin
      w_sel = '0;
      for (int k = 0; k < 9; k++) begin
         if (cyc_q == 4'(k + 1)) begin
            w_sel = KERNEL[k*DATA_W +: DATA_W];
         end
      end
   end

   assign prod     = $signed({{DATA_W{idata[DATA_W-1]}}, idata})
                   * $signed({{DATA_W{w_sel[DATA_W-1]}}, w_sel});
   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

   // ---------------------------------------------------------------------------------------
   // Output stage: bias, round half up, take [FRAC_W +: DATA_W], ReLU, positive saturation.
   // ---------------------------------------------------------------------------------------
   logic signed [ACC_W-1:0] sum;
   logic [DATA_W-1:0]       result;
   logic                    unused_sum_lo;

   always_comb begin
      sum = acc_q
          + $signed({{PAD_W{BIAS[DATA_W-1]}}, BIAS, {FRAC_W{1'b0}}})
          + $signed({{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}});
      if (sum[ACC_W-1]) begin
         result = '0;
      end else if (|sum[ACC_W-2:FRAC_W+DATA_W-1]) begin
         result = {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
         result = sum[FRAC_W +: DATA_W];
      end
   end

   assign unused_sum_lo = ^sum[FRAC_W-1:0];

   // ---------------------------------------------------------------------------------------
   // Next state and outputs
   // ---------------------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cyc_d    = cyc_q;
      x_d      = x_q;
      y_d      = y_q;
      acc_d    = acc_q;
      busy     = (state_q != StIdle);
      iaddr    = tap_ok ? {tap_y, tap_x} : '0;
      cwr      = 1'b0;
      caddr_wr = '0;
      cdata_wr = '0;
      csel     = CSEL_NONE;
`ifdef MAXPOOL_EN
      px_d     = px_q;
      py_d     = py_q;
      max_d    = max_q;
      crd      = 1'b0;
      caddr_rd = '0;
`endif

      case (state_q)
         StIdle: begin
            if (ready) begin
               state_d = StConv;
               cyc_d   = '0;
               x_d     = '0;
               y_d     = '0;
               acc_d   = '0;
            end
         end

         StConv: begin
            // tap_ok_q is the validity of the tap whose data is on idata this cycle.
            if (tap_ok_q) begin
               acc_d = acc_q + prod_ext;
            end
            if (cyc_q == 4'd10) begin
               cwr      = 1'b1;
               csel     = CSEL_L0;
               caddr_wr = {y_q, x_q};
               cdata_wr = result;
               cyc_d    = '0;
               acc_d    = '0;
               x_d      = x_q + X_W'(1);
               if (x_q == X_W'(IMG_W - 1)) begin
                  y_d = y_q + Y_W'(1);
                  if (y_q == Y_W'(IMG_H - 1)) begin
`ifdef MAXPOOL_EN
                     state_d = StPool;
                     px_d    = '0;
                     py_d    = '0;
`else
                     state_d = StDone;
`endif
                  end
               end
            end else begin
               cyc_d = cyc_q + 4'd1;
            end
         end

`ifdef MAXPOOL_EN
         StPool: begin
            // Reads in cycles 0..3 walk (x,y), (x+1,y), (x,y+1), (x+1,y+1) of the 2x2 block.
            if (cyc_q <= 4'd3) begin
               crd      = 1'b1;
               csel     = CSEL_L0;
               caddr_rd = {py_q, cyc_q[1], px_q, cyc_q[0]};
            end
            if (cyc_q == 4'd1) begin
               max_d = cdata_rd;
            end else if ((cyc_q >= 4'd2) && (cyc_q <= 4'd4) && (cdata_rd > max_q)) begin
               max_d = cdata_rd;
            end
            if (cyc_q == 4'd5) begin
               cwr      = 1'b1;
               csel     = CSEL_L1;
               caddr_wr = {2'b00, py_q, px_q};
               cdata_wr = max_q;
               cyc_d    = '0;
               px_d     = px_q + (X_W-1)'(1);
               if (px_q == (X_W-1)'(IMG_W/2 - 1)) begin
                  py_d = py_q + (Y_W-1)'(1);
                  if (py_q == (Y_W-1)'(IMG_H/2 - 1)) begin
                     state_d = StDone;
                  end
               end
            end else begin
               cyc_d = cyc_q + 4'd1;
            end
         end
`endif

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

`ifndef MAXPOOL_EN
   logic unused_rd;

   assign crd       = 1'b0;
   assign caddr_rd  = '0;
   assign unused_rd = ^cdata_rd;
`endif

   // ---------------------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         cyc_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         acc_q    <= '0;
         tap_ok_q <= 1'b0;
`ifdef MAXPOOL_EN
         px_q     <= '0;
         py_q     <= '0;
         max_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         x_q      <= x_d;
         y_q      <= y_d;
         acc_q    <= acc_d;
         tap_ok_q <= tap_ok;
`ifdef MAXPOOL_EN
         px_q     <= px_d;
         py_q     <= py_d;
         max_q    <= max_d;
`endif
      end
   end

endmodule

// File: tb/tb_conv_relu_pool_engine.sv
// tb_conv_relu_pool_engine
//   Drives conv_relu_pool_engine on a small 8x4 image with an asymmetric kernel and checks
//   every result-memory write (select, address, data, cycle) against a reference model
//   computed directly from the convolution / ReLU / max-pool definitions.
`timescale 1ns/1ps
module tb_conv_relu_pool_engine;

   localparam int unsigned IMG_W  = 8;
   localparam int unsigned IMG_H  = 4;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 20;
   localparam int unsigned FRAC_W = 16;
   localparam int unsigned NPIX   = IMG_W * IMG_H;
   localparam int unsigned NPOOL  = NPIX / 4;

   // Taps k=0..8: 1.0, 0.5, -0.25, 2.0, 1.0, -1.0, 0.25, 0.75, 1.5; bias 0.5.
   localparam logic [9*DATA_W-1:0] KERNEL = {20'h18000, 20'h0C000, 20'h04000,
                                             20'hF0000, 20'h10000, 20'h20000,
                                             20'hFC000, 20'h08000, 20'h10000};
   localparam logic [DATA_W-1:0]   BIAS   = 20'h08000;

   longint wt [9] = '{65536, 32768, -16384, 131072, 65536, -65536, 16384, 49152, 98304};
   longint bias_v = 32768;

   logic              clk;
   logic              reset;
   logic              ready;
   logic              busy;
   logic [ADDR_W-1:0] iaddr;
   logic [DATA_W-1:0] idata;
   logic              cwr;
   logic [ADDR_W-1:0] caddr_wr;
   logic [DATA_W-1:0] cdata_wr;
   logic              crd;
   logic [ADDR_W-1:0] caddr_rd;
   logic [DATA_W-1:0] cdata_rd;
   logic [2:0]        csel;

   conv_relu_pool_engine #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .KERNEL (KERNEL),
      .BIAS   (BIAS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ready    (ready),
      .busy     (busy),
      .iaddr    (iaddr),
      .idata    (idata),
      .cwr      (cwr),
      .caddr_wr (caddr_wr),
      .cdata_wr (cdata_wr),
      .crd      (crd),
      .caddr_rd (caddr_rd),
      .cdata_rd (cdata_rd),
      .csel     (csel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memories seen by the DUT
   logic [DATA_W-1:0] img    [NPIX];
   logic [DATA_W-1:0] l0_mem [NPIX];
   logic [DATA_W-1:0] l1_mem [NPOOL];

   always @(posedge clk) idata <= img[iaddr];
   always @(posedge clk) if (crd) cdata_rd <= l0_mem[caddr_rd];

   int n_tot  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ------------------------------------------------------------------ reference model
   typedef struct {
      logic [2:0] sel;
      int         addr;
      longint     data;
      int         when;   // busy cycle number (1 = first busy cycle) of the write
   } wr_t;

   wr_t    exp_q [$];
   longint l0_exp [NPIX];
   int     exp_busy;

   function automatic longint model_px(int x, int y);
      longint acc = 0;
      longint r;
      for (int dy = 0; dy < 3; dy++) begin
         for (int dx = 0; dx < 3; dx++) begin
            int xx = x + dx - 1;
            int yy = y + dy - 1;
            if (xx >= 0 && xx < IMG_W && yy >= 0 && yy < IMG_H)
               acc += longint'($signed(img[yy*IMG_W + xx])) * wt[3*dy + dx];
         end
      end
      acc += bias_v * 65536 + 32768;
      r = acc >>> 16;
      if (r < 0) r = 0;
      else if (r > 524287) r = 524287;
      return r;
   endfunction

   function automatic longint pool4(longint a, longint b, longint c, longint d);
      longint m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   task automatic build_expect();
      wr_t e;
      exp_q.delete();
      for (int y = 0; y < IMG_H; y++) begin
         for (int x = 0; x < IMG_W; x++) begin
            int i = y*IMG_W + x;
            l0_exp[i] = model_px(x, y);
            e.sel = 3'b001; e.addr = i; e.data = l0_exp[i]; e.when = 11*(i + 1);
            exp_q.push_back(e);
         end
      end
      exp_busy = 11*NPIX + 1;
`ifdef MAXPOOL_EN
      for (int py = 0; py < IMG_H/2; py++) begin
         for (int px = 0; px < IMG_W/2; px++) begin
            int j = py*(IMG_W/2) + px;
            int b = 2*py*IMG_W + 2*px;
            e.sel  = 3'b011;
            e.addr = j;
            e.data = pool4(l0_exp[b], l0_exp[b+1], l0_exp[b+IMG_W], l0_exp[b+IMG_W+1]);
            e.when = 11*NPIX + 6*(j + 1);
            exp_q.push_back(e);
         end
      end
      exp_busy += 6*NPOOL;
`endif
   endtask

   // ------------------------------------------------------------------ compare process
   int bcnt     = 0;
   int last_len = 0;

   always @(negedge clk) begin
      wr_t e;
      if (busy) bcnt++;
      else begin
         if (bcnt != 0) last_len = bcnt;
         bcnt = 0;
      end
      if (cwr) begin
         if (csel == 3'b001) l0_mem[caddr_wr] = cdata_wr;
         if (csel == 3'b011 && caddr_wr < NPOOL) l1_mem[caddr_wr] = cdata_wr;
         if (exp_q.size() == 0) chk("no_write_expected", 64'(cwr), 0);
         else begin
            e = exp_q.pop_front();
            chk("wr_sel", csel, e.sel);
            chk("wr_addr", caddr_wr, e.addr);
            chk("wr_data", cdata_wr, e.data);
            chk("wr_cycle", bcnt, e.when);
         end
      end
`ifdef MAXPOOL_EN
      if (crd) begin
         int r = bcnt - 11*NPIX - 1;
         int j = r / 6;
         int c = r % 6;
         int a = (2*(j / (IMG_W/2)) + c/2)*IMG_W + 2*(j % (IMG_W/2)) + c%2;
         chk("rd_sel", csel, 3'b001);
         chk("rd_addr", caddr_rd, a);
      end
`else
      chk("rd_tied_low", {crd, caddr_rd}, 0);
`endif
      if (!cwr && !crd) chk("csel_idle", csel, 0);
   end

   // ------------------------------------------------------------------ stimulus
   task automatic fill_const(input logic [DATA_W-1:0] v);
      for (int i = 0; i < NPIX; i++) img[i] = v;
   endtask

   task automatic fill_random();
      for (int i = 0; i < NPIX; i++) begin
         if ($urandom_range(0, 3) == 0) img[i] = DATA_W'($urandom);
         else img[i] = DATA_W'($urandom_range(0, 32'h40000)) - 20'h20000;
      end
   endtask

   task automatic clear_mems();
      for (int i = 0; i < NPIX; i++) l0_mem[i] = 20'hABCDE;
      for (int i = 0; i < NPOOL; i++) l1_mem[i] = 20'hABCDE;
   endtask

   task automatic run_image(input bit poke_ready);
      int limit;
      clear_mems();
      build_expect();
      @(negedge clk); ready = 1'b1;
      @(negedge clk); ready = 1'b0;
      if (poke_ready) begin
         repeat (40) @(negedge clk);
         ready = 1'b1;
         @(negedge clk); ready = 1'b0;
      end
      limit = exp_busy + 20;
      while (busy && limit > 0) begin
         @(negedge clk);
         limit--;
      end
      chk("busy_timeout", 64'(busy), 0);
      @(negedge clk);
      // busy-high cycles; with the ready cycle before it this is 1 + 11*N [+ 6*N/4] + 1.
      chk("busy_cycles", last_len, exp_busy);
      chk("writes_left", exp_q.size(), 0);
      if (poke_ready) begin
         repeat (15) @(negedge clk);
         chk("no_restart", 64'(busy), 0);
      end
   endtask

   initial begin
      repeat (30000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      ready = 1'b0;
      fill_const('0);
      clear_mems();
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_cwr", 64'(cwr), 0);
      chk("rst_crd", 64'(crd), 0);
      chk("rst_csel", csel, 0);
      chk("rst_iaddr", iaddr, 0);
      chk("rst_caddr_wr", caddr_wr, 0);
      chk("rst_cdata_wr", cdata_wr, 0);
      chk("rst_caddr_rd", caddr_rd, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // All-zero image: every result is the bias, 0.5.
      fill_const('0);
      run_image(1'b0);
      chk("zero_img_first", l0_mem[0], 20'h08000);
      chk("zero_img_last", l0_mem[NPIX-1], 20'h08000);

      // Constant 1.0: interior 5.75+0.5, corners/edges see only in-bounds taps.
      fill_const(20'h10000);
      run_image(1'b0);
      chk("one_img_interior", l0_mem[IMG_W+1], 20'h64000);
      chk("one_img_corner_tl", l0_mem[0], 20'h2C000);
      chk("one_img_corner_br", l0_mem[NPIX-1], 20'h50000);
      chk("one_img_left_edge", l0_mem[IMG_W], 20'h30000);
      chk("one_img_top_edge", l0_mem[1], 20'h50000);
`ifdef MAXPOOL_EN
      chk("one_img_pool0", l1_mem[0], 20'h64000);
      chk("pool_model_pin", pool4(1, 7, 3, 2), 7);
`endif

      // Constant -1.0: all sums negative, ReLU clamps to 0.
      fill_const(20'hF0000);
      run_image(1'b0);
      chk("neg_img_interior", l0_mem[IMG_W+1], 0);
      chk("neg_img_corner", l0_mem[0], 0);
      chk("neg_img_last", l0_mem[NPIX-1], 0);
`ifdef MAXPOOL_EN
      chk("neg_img_pool0", l1_mem[0], 0);
`endif

      // Near-max image: interior overflows and saturates.
      fill_const(20'h7FFFF);
      run_image(1'b0);
      chk("sat_interior", l0_mem[IMG_W+1], 20'h7FFFF);

      // Random images, one with a ready pulse while busy.
      fill_random();
      run_image(1'b0);
      fill_random();
      run_image(1'b1);

      // Reset held low 3 cycles mid-convolution.
      fill_random();
      clear_mems();
      build_expect();
      @(negedge clk); ready = 1'b1;
      @(negedge clk); ready = 1'b0;
      repeat (60) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      exp_q.delete();
      chk("midrst_busy", 64'(busy), 0);
      chk("midrst_cwr", 64'(cwr), 0);
      chk("midrst_crd", 64'(crd), 0);
      chk("midrst_csel", csel, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      chk("midrst_stays_idle", 64'(busy), 0);

      // Full recovery after reset.
      fill_random();
      run_image(1'b0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
